// File: rtl/windowed_register_decoder_if.sv
// Bus between the control unit (master) and the windowed write-enable decoder (slave).
// Carries the write request, the window-pointer controls and the decoded results.
interface windowed_register_decoder_if #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1,
    parameter int PHYS     = 8 + 16 * NWINDOWS
);
    logic                RF_Ld;
    logic [4:0]          Register_Select;
    logic                Save;
    logic                Restore;
    logic                CWP_Ld;
    logic [CWP_W-1:0]    CWP_In;
    logic [NWINDOWS-1:0] WIM;
    logic [PHYS-1:0]     Register_Enable;
    logic [CWP_W-1:0]    CWP_Out;
    logic                Window_Overflow;
    logic                Window_Underflow;
    logic                CWP_Error;

    modport master (
        output RF_Ld, Register_Select, Save, Restore, CWP_Ld, CWP_In, WIM,
        input  Register_Enable, CWP_Out, Window_Overflow, Window_Underflow, CWP_Error
    );

    modport slave (
        input  RF_Ld, Register_Select, Save, Restore, CWP_Ld, CWP_In, WIM,
        output Register_Enable, CWP_Out, Window_Overflow, Window_Underflow, CWP_Error
    );
endinterface

// File: rtl/windowed_register_decoder.sv
// Registered one-hot write-enable decoder for a SPARC windowed register file.
// Owns the current window pointer and handles SAVE/RESTORE with WIM trap detection.
module windowed_register_decoder #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1,
    parameter int PHYS     = 8 + 16 * NWINDOWS,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    windowed_register_decoder_if.slave    bus
);

    logic [CWP_W-1:0] cwp_reg, cwp_next;
    logic [CWP_W-1:0] cwp_inc, cwp_dec;
    logic [PHYS-1:0]  enable_reg, enable_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             error_reg, error_next;
    logic [31:0]      sel_idx;
    logic [31:0]      reg_num;
    logic             sel_hit;

    // Neighbouring windows with explicit wrap, so non-power-of-two counts work too.
    always_comb begin
        cwp_inc = (cwp_reg == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_reg + CWP_W'(1);
        cwp_dec = (cwp_reg == '0) ? CWP_W'(NWINDOWS - 1) : cwp_reg - CWP_W'(1);
    end

    // Physical index always uses the pre-update window pointer.
    always_comb begin
        reg_num = 32'(bus.Register_Select);
        sel_idx = '0;
        case (bus.Register_Select[4:3])
            2'd0: sel_idx = reg_num;
            2'd1: sel_idx = 32'd8  + 32'd16 * 32'(cwp_reg) + (reg_num - 32'd8);
            2'd2: sel_idx = 32'd16 + 32'd16 * 32'(cwp_reg) + (reg_num - 32'd16);
            default: sel_idx = 32'd8 + 32'd16 * 32'(cwp_inc) + (reg_num - 32'd24);
        endcase
        sel_hit = bus.RF_Ld && !(ZERO_R0 && (reg_num == 32'd0));
    end

    for (genvar gi = 0; gi < PHYS; gi++) begin : g_enable
        assign enable_next[gi] = sel_hit && (sel_idx == 32'(gi));
    end

    // Direct load wins; Save and Restore together cancel each other.
    always_comb begin
        cwp_next       = cwp_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        error_next     = 1'b0;
        if (bus.CWP_Ld) begin
            if (32'(bus.CWP_In) < 32'(NWINDOWS)) begin
                cwp_next = bus.CWP_In;
            end else begin
                error_next = 1'b1;
            end
        end else if (bus.Save && !bus.Restore) begin
            if (bus.WIM[cwp_dec]) begin
                overflow_next = 1'b1;
            end else begin
                cwp_next = cwp_dec;
            end
        end else if (bus.Restore && !bus.Save) begin
            if (bus.WIM[cwp_inc]) begin
                underflow_next = 1'b1;
            end else begin
                cwp_next = cwp_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cwp_reg       <= '0;
            enable_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            cwp_reg       <= cwp_next;
            enable_reg    <= enable_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            error_reg     <= error_next;
        end
    end

    assign bus.Register_Enable  = enable_reg;
    assign bus.CWP_Out          = cwp_reg;
    assign bus.Window_Overflow  = overflow_reg;
    assign bus.Window_Underflow = underflow_reg;
    assign bus.CWP_Error        = error_reg;

endmodule

// File: tb/tb_windowed_register_decoder.sv
// Scoreboard bench for windowed_register_decoder (NWINDOWS=4, PHYS=72, ZERO_R0=1).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_windowed_register_decoder;

    localparam int NW   = 4;
    localparam int CW   = 2;
    localparam int PH   = 72;

    typedef struct packed {
        logic [PH-1:0] en;
        logic [CW-1:0] cwp;
        logic          ovf;
        logic          unf;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_txn;
    exp_t exp_q[$];

    windowed_register_decoder_if #(.NWINDOWS(NW)) bus ();

    windowed_register_decoder #(.NWINDOWS(NW), .ZERO_R0(1'b1)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PH-1:0] onehot(input int idx);
        logic [PH-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [PH-1:0] act, input logic [PH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL txn %0d %s: actual=%h required=%h", n_txn, name, act, req);
        end
    endtask

    // Monitor: every cycle after a sampled transaction, compare the registered outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("enable",    bus.Register_Enable,          e.en);
            check("cwp",       PH'(bus.CWP_Out),             PH'(e.cwp));
            check("overflow",  PH'(bus.Window_Overflow),     PH'(e.ovf));
            check("underflow", PH'(bus.Window_Underflow),    PH'(e.unf));
            check("cwp_error", PH'(bus.CWP_Error),           PH'(e.err));
            $display("txn %0d: enable=%h cwp=%0d ovf=%b unf=%b err=%b",
                     n_txn, bus.Register_Enable, bus.CWP_Out,
                     bus.Window_Overflow, bus.Window_Underflow, bus.CWP_Error);
            n_txn++;
        end
    end

    // Drive one cycle of inputs; after the sampling edge, queue what must appear.
    task automatic step(input logic r, input logic ld, input logic [4:0] sel,
                        input logic sv, input logic rs, input logic cl,
                        input logic [CW-1:0] cin, input logic [NW-1:0] wim,
                        input int e_idx, input logic [CW-1:0] e_cwp,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        rst                 = r;
        bus.RF_Ld           = ld;
        bus.Register_Select = sel;
        bus.Save            = sv;
        bus.Restore         = rs;
        bus.CWP_Ld          = cl;
        bus.CWP_In          = cin;
        bus.WIM             = wim;
        @(posedge clk);
        e.en  = onehot(e_idx);
        e.cwp = e_cwp;
        e.ovf = e_ovf;
        e.unf = e_unf;
        e.err = 1'b0;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_txn    = 0;
        rst = 1'b1;
        bus.RF_Ld = 1'b0; bus.Register_Select = '0; bus.Save = 1'b0; bus.Restore = 1'b0;
        bus.CWP_Ld = 1'b0; bus.CWP_In = '0; bus.WIM = '0;
        //    rst  ld  sel    sv  rs  cl  cin  wim      idx cwp ovf unf
        step(1, 0, 5'd0,  0, 0, 0, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(1, 0, 5'd0,  0, 0, 0, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(0, 1, 5'd9,  0, 0, 0, 2'd0, 4'b0000,  9, 2'd0, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd3, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 1, 5'd17, 0, 0, 0, 2'd0, 4'b0000, 65, 2'd3, 0, 0);
        step(0, 1, 5'd25, 0, 0, 0, 2'd0, 4'b0000,  9, 2'd3, 0, 0);
        step(0, 1, 5'd0,  0, 0, 0, 2'd0, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 1, 5'd3,  0, 0, 0, 2'd0, 4'b0000,  3, 2'd3, 0, 0);
        step(0, 0, 5'd3,  0, 0, 0, 2'd0, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(0, 0, 5'd0,  1, 0, 0, 2'd0, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(0, 0, 5'd0,  1, 0, 0, 2'd0, 4'b1000, -1, 2'd0, 1, 0);
        step(0, 0, 5'd0,  0, 0, 0, 2'd0, 4'b1000, -1, 2'd0, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd3, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 0, 5'd0,  0, 1, 0, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd3, 4'b0000, -1, 2'd3, 0, 0);
        step(0, 0, 5'd0,  0, 1, 0, 2'd0, 4'b0001, -1, 2'd3, 0, 1);
        step(0, 0, 5'd0,  0, 0, 0, 2'd0, 4'b0001, -1, 2'd3, 0, 0);
        step(0, 0, 5'd0,  1, 0, 1, 2'd2, 4'b0000, -1, 2'd2, 0, 0);
        step(0, 0, 5'd0,  1, 1, 0, 2'd0, 4'b0000, -1, 2'd2, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd1, 4'b0000, -1, 2'd1, 0, 0);
        step(0, 1, 5'd8,  1, 0, 0, 2'd0, 4'b0000, 24, 2'd0, 0, 0);
        step(0, 1, 5'd31, 0, 0, 0, 2'd0, 4'b0000, 31, 2'd0, 0, 0);
        step(0, 1, 5'd23, 0, 0, 0, 2'd0, 4'b0000, 23, 2'd0, 0, 0);
        step(0, 1, 5'd15, 0, 0, 0, 2'd0, 4'b0000, 15, 2'd0, 0, 0);
        step(0, 0, 5'd0,  0, 0, 1, 2'd2, 4'b0000, -1, 2'd2, 0, 0);
        step(1, 1, 5'd9,  1, 0, 0, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        step(0, 0, 5'd0,  0, 0, 0, 2'd0, 4'b0000, -1, 2'd0, 0, 0);
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
